// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - decoder/control bundle between sequencer and program counter unit
// Master drives start and decoder controls; slave returns ROM address and run status.
interface pc_unit_if #(
   parameter int PW = 10
);
   logic          Start;
   logic [PW-1:0] StartAddr;
   logic          JumpEqual;
   logic          JumpNotEqual;
   logic          OffsetEn;
   logic [1:0]    PCRegSelect;
   logic          Ack;
   logic          Zero;
   logic [7:0]    R8Data;
   logic [PW-1:0] ProgCtr;
   logic          Running;
   logic          Done;

   modport master (
      output Start, StartAddr, JumpEqual, JumpNotEqual, OffsetEn,
             PCRegSelect, Ack, Zero, R8Data,
      input  ProgCtr, Running, Done
   );

   modport slave (
      input  Start, StartAddr, JumpEqual, JumpNotEqual, OffsetEn,
             PCRegSelect, Ack, Zero, R8Data,
      output ProgCtr, Running, Done
   );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with three link registers and IDLE/RUN/HALT sequencing
// One instruction per RUN cycle; priority is Ack > jump > save > increment.
module pc_unit #(
   parameter int PW = 10
) (
   input  logic     Clk,
   input  logic     Reset,
   pc_unit_if.slave bus
);
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] HALT = 2'b10;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pc_q, pc_d;
   logic [PW-1:0] link1_q, link1_d;
   logic [PW-1:0] link2_q, link2_d;
   logic [PW-1:0] link3_q, link3_d;
   logic          running_q, running_d;
   logic          done_q, done_d;

   logic [PW-1:0] pc_inc;
   logic [PW-1:0] offset;
   logic [PW-1:0] save_addr;
   logic [PW-1:0] link_sel;
   logic          sel_valid;
   logic          cond_met;
   logic          any_jump;
   logic          do_jump;
   logic          do_save;

   assign pc_inc    = pc_q + PW'(1);
   // R8Data is a signed byte; the size cast sign-extends it to PW bits.
   assign offset    = bus.OffsetEn ? PW'($signed(bus.R8Data)) : '0;
   assign save_addr = pc_inc + offset;
   assign sel_valid = (bus.PCRegSelect != 2'b00);
   assign any_jump  = bus.JumpEqual | bus.JumpNotEqual;
   assign cond_met  = (bus.JumpEqual & bus.Zero) | (bus.JumpNotEqual & ~bus.Zero);
   assign do_jump   = sel_valid & cond_met;
   assign do_save   = sel_valid & ~any_jump;

   always_comb begin
      link_sel = link3_q;
      case (bus.PCRegSelect)
         2'b01:   link_sel = link1_q;
         2'b10:   link_sel = link2_q;
         default: link_sel = link3_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      link1_d = link1_q;
      link2_d = link2_q;
      link3_d = link3_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               pc_d    = bus.StartAddr;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.Ack) begin
               state_d = HALT;
            end else if (do_jump) begin
               pc_d = link_sel;
            end else begin
               pc_d = pc_inc;
               if (do_save) begin
                  case (bus.PCRegSelect)
                     2'b01:   link1_d = save_addr;
                     2'b10:   link2_d = save_addr;
                     default: link3_d = save_addr;
                  endcase
               end
            end
         end
         HALT: begin
            if (bus.Start) begin
               pc_d    = bus.StartAddr;
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
      running_d = (state_d == RUN);
      done_d    = (state_d == HALT);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         link1_q   <= '0;
         link2_q   <= '0;
         link3_q   <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         link1_q   <= link1_d;
         link2_q   <= link2_d;
         link3_q   <= link3_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign bus.ProgCtr = pc_q;
   assign bus.Running = running_q;
   assign bus.Done    = done_q;
endmodule
